givens_bram_ctrl: RTL and testbench

//  Sequencer for the dual-port Givens-matrix BRAM (bram_givens).
//  - Accepts one (cos, sin) coefficient pair per rotation.
//  - Writes G = [c -s; s c] row-major through port A.
//  - Reads the four words back through port B.
//  - Streams them to the rotation engine over a valid/ready interface.
//  - Absorbs the fixed BRAM read latency with a credit-limited output buffer.
//

---
 rtl/givens_bram_ctrl_pkg.sv | 32 +++
 rtl/givens_out_fifo.sv | 62 ++++++
 rtl/givens_bram_ctrl.sv | 174 +++++++++++++++++
 tb/tb_givens_bram_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/givens_bram_ctrl_pkg.sv
// Shared definitions for the Givens-matrix BRAM sequencer.
//   DATA_W    : coefficient / BRAM word width (Q16.16 two's complement)
//   ADDR_W    : BRAM address width (four matrix words)
//   RD_LAT    : port B read latency, issue cycle to buffer capture
//   OUT_DEPTH : output buffer depth
//   givens_ctrl_state_t : sequencer states
//   GIVENS_IDX_* : row-major addresses of G = [c -s; s c]
//   neg_sat() : saturating negation
package givens_bram_ctrl_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 2;
  localparam int RD_LAT    = 2;
  localparam int OUT_DEPTH = 2;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} givens_ctrl_state_t;

  localparam logic [ADDR_W-1:0] GIVENS_IDX_00 = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] GIVENS_IDX_01 = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] GIVENS_IDX_10 = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] GIVENS_IDX_11 = ADDR_W'(3);

  // -x, except the most negative value, whose negation is not representable,
  // maps to the most positive value.
  function automatic logic signed [DATA_W-1:0] neg_sat(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] most_neg;
    most_neg = {1'b1, {(DATA_W-1){1'b0}}};
    if (x == most_neg) return ~most_neg;
    return -x;
  endfunction

endpackage

// File: rtl/givens_out_fifo.sv
// Small synchronous FIFO used as the credit-limited output buffer.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push_i     : write data_i (never while full)
//   pop_i      : drop the head entry (never while empty)
//   data_i     : entry written on push
//   head_o     : current head entry
//   count_o    : number of stored entries
//   empty_o    : no entries stored
module givens_out_fifo #(
  parameter int DATA_W = 34,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              full;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_i && !pop_i)      count_q <= count_q + CNT_W'(1);
      else if (pop_i && !push_i) count_q <= count_q - CNT_W'(1);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  // The controller's credit rule must keep the buffer from overflowing.
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && empty_o));

endmodule

// File: rtl/givens_bram_ctrl.sv
// Sequencer for the dual-port Givens-matrix BRAM.
// Accepts a (cos, sin) pair, writes G = [c -s; s c] row-major through port A,
// reads it back through port B and streams the words over valid/ready.
//   coef_valid/coef_ready, cos_in, sin_in : coefficient pair input
//   ena/wea/addra/dina_givens             : BRAM port A (write)
//   ena/wea/addra_rotation, douta_rotation: BRAM port B (read)
//   rot_valid/rot_ready, rot_data, rot_idx, rot_last : output stream
//   busy : not idle;  done : one-cycle pulse after the idx-3 handshake
module givens_bram_ctrl
  import givens_bram_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     coef_valid,
  output logic                     coef_ready,
  input  logic signed [DATA_W-1:0] cos_in,
  input  logic signed [DATA_W-1:0] sin_in,
  output logic                     ena_givens,
  output logic                     wea_givens,
  output logic [ADDR_W-1:0]        addra_givens,
  output logic [DATA_W-1:0]        dina_givens,
  output logic                     ena_rotation,
  output logic                     wea_rotation,
  output logic [ADDR_W-1:0]        addra_rotation,
  input  logic [DATA_W-1:0]        douta_rotation,
  output logic                     rot_valid,
  input  logic                     rot_ready,
  output logic [DATA_W-1:0]        rot_data,
  output logic [ADDR_W-1:0]        rot_idx,
  output logic                     rot_last,
  output logic                     busy,
  output logic                     done
);

  // The issue cycle is the first of the RD_LAT stages; the remaining stages
  // are registers, and douta_rotation is captured as the last one leaves.
  // RD_LAT must be at least 2.
  localparam int PIPE_D    = RD_LAT - 1;
  localparam int BUF_CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int BUF_W     = DATA_W + ADDR_W;

  givens_ctrl_state_t       state_q, state_d;
  logic signed [DATA_W-1:0] cos_q, sin_q, wr_word;
  logic [ADDR_W-1:0]        wr_cnt_q;
  logic [ADDR_W:0]          rd_cnt_q;
  logic [PIPE_D-1:0]        vld_pipe_q;
  logic [ADDR_W-1:0]        idx_pipe_q [PIPE_D];
  logic [BUF_CNT_W-1:0]     buf_cnt;
  logic [BUF_W-1:0]         buf_head;
  logic                     buf_empty, buf_pop, issue, head_last;
  int                       inflight;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < PIPE_D; i++) inflight += int'(vld_pipe_q[i]);
  end

  assign buf_pop   = !buf_empty && rot_ready;
  assign head_last = (buf_head[BUF_W-1 -: ADDR_W] == GIVENS_IDX_11);

  // A word popped this cycle returns its credit immediately, which is what
  // lets OUT_DEPTH == RD_LAT sustain one word per cycle.
  assign issue = (state_q == DRAIN) && !rd_cnt_q[ADDR_W] &&
                 ((inflight + int'(buf_cnt) - int'(buf_pop)) < OUT_DEPTH);

  always_comb begin
    unique case (wr_cnt_q)
      GIVENS_IDX_00: wr_word = cos_q;
      GIVENS_IDX_01: wr_word = neg_sat(sin_q);
      GIVENS_IDX_10: wr_word = sin_q;
      default:       wr_word = cos_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (coef_valid) state_d = LOAD;
      LOAD:    if (wr_cnt_q == GIVENS_IDX_11) state_d = DRAIN;
      DRAIN:   if (buf_pop && head_last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    coef_ready   = 1'b0;
    ena_givens   = 1'b0;
    wea_givens   = 1'b0;
    addra_givens = '0;
    dina_givens  = '0;
    busy         = 1'b1;
    done         = 1'b0;
    unique case (state_q)
      IDLE: begin
        coef_ready = 1'b1;
        busy       = 1'b0;
      end
      LOAD: begin
        ena_givens   = 1'b1;
        wea_givens   = 1'b1;
        addra_givens = wr_cnt_q;
        dina_givens  = wr_word;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
    ena_rotation   = issue;
    wea_rotation   = 1'b0;
    addra_rotation = issue ? rd_cnt_q[ADDR_W-1:0] : '0;
    rot_valid      = !buf_empty;
    rot_data       = buf_empty ? '0 : buf_head[DATA_W-1:0];
    rot_idx        = buf_empty ? '0 : buf_head[BUF_W-1 -: ADDR_W];
    rot_last       = !buf_empty && head_last;
  end

  // Coefficient capture on acceptance
  always_ff @(posedge clk) begin
    if (state_q == IDLE && coef_valid) begin
      cos_q <= cos_in;
      sin_q <= sin_in;
    end
  end

  // Write/read counters; wr_cnt wraps back to 0 as LOAD ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (state_q == LOAD) wr_cnt_q <= wr_cnt_q + ADDR_W'(1);
      if (state_q != DRAIN) rd_cnt_q <= '0;
      else if (issue)       rd_cnt_q <= rd_cnt_q + (ADDR_W+1)'(1);
    end
  end

  // Read latency pipe: valid bits are control, index travels alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= issue;
      for (int i = 1; i < PIPE_D; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    idx_pipe_q[0] <= rd_cnt_q[ADDR_W-1:0];
    for (int i = 1; i < PIPE_D; i++) idx_pipe_q[i] <= idx_pipe_q[i-1];
  end

  givens_out_fifo #(
    .DATA_W (BUF_W),
    .DEPTH  (OUT_DEPTH),
    .CNT_W  (BUF_CNT_W)
  ) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (vld_pipe_q[PIPE_D-1]),
    .pop_i   (buf_pop),
    .data_i  ({idx_pipe_q[PIPE_D-1], douta_rotation}),
    .head_o  (buf_head),
    .count_o (buf_cnt),
    .empty_o (buf_empty)
  );

endmodule

// File: tb/tb_givens_bram_ctrl.sv
// Self-checking bench for givens_bram_ctrl with a behavioural BRAM and a
// reference model that derives the expected matrix words from (c, s).
module tb_givens_bram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        coef_valid = 1'b0;
  logic        coef_ready;
  logic [31:0] cos_in = '0;
  logic [31:0] sin_in = '0;
  logic        ena_givens, wea_givens;
  logic [1:0]  addra_givens;
  logic [31:0] dina_givens;
  logic        ena_rotation, wea_rotation;
  logic [1:0]  addra_rotation;
  logic [31:0] douta_rotation;
  logic        rot_valid;
  logic        rot_ready = 1'b0;
  logic [31:0] rot_data;
  logic [1:0]  rot_idx;
  logic        rot_last, busy, done;

  always #5 clk = ~clk;

  givens_bram_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .cos_in(cos_in), .sin_in(sin_in),
    .ena_givens(ena_givens), .wea_givens(wea_givens),
    .addra_givens(addra_givens), .dina_givens(dina_givens),
    .ena_rotation(ena_rotation), .wea_rotation(wea_rotation),
    .addra_rotation(addra_rotation), .douta_rotation(douta_rotation),
    .rot_valid(rot_valid), .rot_ready(rot_ready),
    .rot_data(rot_data), .rot_idx(rot_idx), .rot_last(rot_last),
    .busy(busy), .done(done)
  );

  // BRAM: port B registers the addressed word on the edge after the read
  logic [31:0] mem [4];
  logic [31:0] rd_q = '0;
  initial for (int i = 0; i < 4; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (ena_givens && wea_givens) mem[addra_givens] <= dina_givens;
    if (ena_rotation) rd_q <= mem[addra_rotation];
  end
  assign douta_rotation = rd_q;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation logs, restarted at each pair acceptance
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          rd_idx_q[$];
  logic [31:0] rd_data_q[$];
  bit          rd_last_q[$];
  int issues, hs, done_cnt, first_issue, first_valid, last_hs, acc_cyc;
  bit last_was_final;
  bit prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [1:0]  prev_idx;

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete();
    rd_idx_q.delete(); rd_data_q.delete(); rd_last_q.delete();
    issues = 0; hs = 0; done_cnt = 0;
    first_issue = -1; first_valid = -1; last_hs = -1;
    last_was_final = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ena_givens && wea_givens) begin
        wr_addr_q.push_back(int'(addra_givens));
        wr_data_q.push_back(dina_givens);
      end
      if (prev_stall)
        check("stall_hold", {rot_valid, rot_idx, rot_data}, {1'b1, prev_idx, prev_data});
      if (ena_rotation) begin
        if (first_issue < 0) first_issue = cyc;
        check("credit_le_2", 64'((issues + 1 - hs - int'(rot_valid && rot_ready)) <= 2), 64'd1);
        issues++;
      end
      if (rot_valid && first_valid < 0) first_valid = cyc;
      if (done) begin
        done_cnt++;
        check("done_gap", 64'(cyc - last_hs), 64'd1);
        check("done_after_last", 64'(last_was_final), 64'd1);
      end
      if (rot_valid && rot_ready) begin
        rd_idx_q.push_back(int'(rot_idx));
        rd_data_q.push_back(rot_data);
        rd_last_q.push_back(rot_last);
        hs++;
        last_hs = cyc;
        last_was_final = rot_last;
      end
      prev_stall = rot_valid && !rot_ready;
      prev_data  = rot_data;
      prev_idx   = rot_idx;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Present a pair and wait for it to be taken; returns just after the
  // accepting edge. coef_valid is left high for the caller to manage.
  task automatic send(input logic [31:0] c, input logic [31:0] s);
    int n;
    coef_valid = 1'b1;
    cos_in = c;
    sin_in = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!coef_ready && n < 50);
    if (!coef_ready) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    clear_logs();
  endtask

  function automatic bit ready_for(input int mode, input int k);
    bit [5:0] pat;
    pat = 6'b101001;  // k%6 = 0..5 -> 1,0,0,1,0,1
    if (mode == 0) return 1'b1;
    if (mode == 1) return pat[k % 6];
    return 1'($urandom_range(0, 1));
  endfunction

  // Run until done, then compare everything observed against the model.
  task automatic collect(input logic [31:0] c, input logic [31:0] s,
                         input int mode, input bit chk_lat);
    logic [31:0] exp_w [4];
    bit seen;
    exp_w[0] = c;
    exp_w[1] = (s == 32'h8000_0000) ? 32'h7FFF_FFFF : 32'd0 - s;
    exp_w[2] = s;
    exp_w[3] = c;
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      rot_ready = ready_for(mode, k);
      @(negedge clk);
      if (busy && coef_valid) check("ready_while_busy", 64'(coef_ready), 64'd0);
      seen = done;
      @(posedge clk); #1;
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    check("n_writes", 64'(wr_addr_q.size()), 64'd4);
    check("n_words", 64'(rd_data_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_addr_q.size()) begin
        check("wr_addr", 64'(wr_addr_q[i]), 64'(i));
        check("wr_data", 64'(wr_data_q[i]), 64'(exp_w[i]));
      end
      if (i < rd_data_q.size()) begin
        check("rot_idx", 64'(rd_idx_q[i]), 64'(i));
        check("rot_data", 64'(rd_data_q[i]), 64'(exp_w[i]));
        check("rot_last", 64'(rd_last_q[i]), 64'(i == 3));
      end
    end
    check("done_pulses", 64'(done_cnt), 64'd1);
    if (chk_lat) begin
      check("lat_first_issue", 64'(first_issue - acc_cyc), 64'd4);
      check("lat_first_valid", 64'(first_valid - acc_cyc), 64'd6);
      check("lat_last_hs", 64'(last_hs - acc_cyc), 64'd9);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {49'd0, coef_ready, ena_givens, wea_givens, addra_givens, ena_rotation,
                wea_rotation, addra_rotation, rot_valid, rot_idx, rot_last, busy, done},
          64'h4000);
    check({tag, "_data"}, {dina_givens, rot_data}, 64'd0);
  endtask

  initial begin
    logic [31:0] c, s;
    int mode;
    clear_logs();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_init");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Nominal pair, full throughput
    send(32'h0000_B505, 32'h0000_B505);
    coef_valid = 1'b0;
    collect(32'h0000_B505, 32'h0000_B505, 0, 1'b1);

    // Same pair with a stalling consumer
    send(32'h0000_B505, 32'h0000_B505);
    coef_valid = 1'b0;
    collect(32'h0000_B505, 32'h0000_B505, 1, 1'b0);

    // Saturating negation of the most negative sine
    send(32'h0000_0000, 32'h8000_0000);
    coef_valid = 1'b0;
    collect(32'h0000_0000, 32'h8000_0000, 0, 1'b1);

    // coef_valid held through the whole operation with new data behind it
    send(32'h1234_5678, 32'hFEDC_BA98);
    cos_in = 32'h0BAD_F00D;
    sin_in = 32'hC001_D00D;
    collect(32'h1234_5678, 32'hFEDC_BA98, 0, 1'b1);
    send(32'h0BAD_F00D, 32'hC001_D00D);
    coef_valid = 1'b0;
    collect(32'h0BAD_F00D, 32'hC001_D00D, 2, 1'b0);

    // Reset in the second DRAIN cycle, then a fresh pair
    send(32'h0000_B505, 32'h0000_B505);
    coef_valid = 1'b0;
    rot_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("drain_reached", 64'(ena_rotation), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_mid");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_hold");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(32'h0001_0000, 32'h0000_0000);
    coef_valid = 1'b0;
    collect(32'h0001_0000, 32'h0000_0000, 2, 1'b0);

    // Randomized pairs and consumer behaviour
    for (int t = 0; t < 8; t++) begin
      c = $urandom;
      s = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      mode = $urandom_range(0, 2);
      send(c, s);
      coef_valid = 1'b0;
      collect(c, s, mode, mode == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
